fq_demux: RTL and testbench



---
 rtl/fq_pkg.sv | 17 +
 rtl/fq_sat_counter.sv | 27 ++
 rtl/fq_demux.sv | 168 ++++++++++++++++
 tb/tb_fq_demux.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// fq_pkg: constants, word type and demux state encoding shared by the fair-queue blocks.
`default_nettype none

package fq_pkg;
  localparam int COUNT_LSB = 0;
  localparam int COUNT_W   = 8;
  localparam int DEST_LSB  = 8;

  typedef logic [63:0] fq_word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } fq_demux_state_t;
endpackage

`default_nettype wire

// File: rtl/fq_sat_counter.sv
// ----------------------------------------------------------------------------
// fq_sat_counter: up-counter that either saturates at all-ones or wraps.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fq_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !(SATURATE && (&count))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fq_demux.sv
// ----------------------------------------------------------------------------
// fq_demux: splits the fair-queue output stream into bursts and steers them
// into per-destination FIFOs. Optional statistics: FQ_DEMUX_STATS_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fq_demux
  import fq_pkg::*;
#(
  parameter  int NUM_OUT_LOG2 = 3,
  parameter  int TIMEOUT      = 16,
  localparam int NUM_OUT      = 1 << NUM_OUT_LOG2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  fq_word_t in_data,
  input  logic     fifo_full   [NUM_OUT],
  output logic     fifo_wrreq  [NUM_OUT],
  output fq_word_t fifo_wrdata [NUM_OUT],
  output logic     burst_done,
  output logic     burst_dropped,
  output logic     burst_error
`ifdef FQ_DEMUX_STATS_EN
  ,
  output logic [31:0] stat_words [NUM_OUT],
  output logic [15:0] stat_drops,
  output logic [15:0] stat_timeouts
`endif
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  fq_demux_state_t           state, state_nxt;
  logic [NUM_OUT_LOG2-1:0]   dest, dest_nxt, hdr_dest, cur_dest;
  logic [COUNT_W-1:0]        remaining, remaining_nxt, hdr_n;
  logic                      drop, drop_nxt;
  logic [7:0]                idle_cnt, idle_cnt_nxt;
  logic                      cur_full, last_word, drop_now, timeout_hit;
  logic [NUM_OUT-1:0]        wrreq_nxt;
  logic                      done_nxt, dropped_nxt, error_nxt;

  assign hdr_n    = in_data[COUNT_LSB +: COUNT_W];
  assign hdr_dest = in_data[DEST_LSB +: NUM_OUT_LOG2];
  assign cur_dest = (state == IDLE) ? hdr_dest : dest;
  assign cur_full = fifo_full[cur_dest];
  // A header with N of 0 or 1 is its own last word.
  assign last_word   = (state == IDLE) ? (hdr_n <= COUNT_W'(1)) : (remaining == COUNT_W'(1));
  assign drop_now    = ((state == BURST) && drop) || cur_full;
  assign timeout_hit = (state == BURST) && !in_valid && ((idle_cnt + 8'd1) == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dest      <= '0;
      remaining <= '0;
      drop      <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      dest      <= dest_nxt;
      remaining <= remaining_nxt;
      drop      <= drop_nxt;
      idle_cnt  <= idle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dest_nxt      = dest;
    remaining_nxt = remaining;
    drop_nxt      = drop;
    idle_cnt_nxt  = idle_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          dest_nxt      = hdr_dest;
          remaining_nxt = hdr_n - COUNT_W'(1);
          idle_cnt_nxt  = '0;
          if (last_word) begin
            drop_nxt = 1'b0;
          end else begin
            state_nxt = BURST;
            drop_nxt  = drop_now;
          end
        end
      end
      BURST: begin
        if (in_valid) begin
          remaining_nxt = remaining - COUNT_W'(1);
          idle_cnt_nxt  = '0;
          if (last_word) begin
            state_nxt = IDLE;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt = drop_now;
          end
        end else if (timeout_hit) begin
          state_nxt    = IDLE;
          drop_nxt     = 1'b0;
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wrreq_nxt           = '0;
    wrreq_nxt[cur_dest] = in_valid && !drop_now;
    done_nxt            = in_valid && last_word;
    dropped_nxt         = done_nxt && drop_now;
    error_nxt           = timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        fifo_wrreq[i]  <= 1'b0;
        fifo_wrdata[i] <= '0;
      end
      burst_done    <= 1'b0;
      burst_dropped <= 1'b0;
      burst_error   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        fifo_wrreq[i] <= wrreq_nxt[i];
        if (wrreq_nxt[i]) begin
          fifo_wrdata[i] <= in_data;
        end
      end
      burst_done    <= done_nxt;
      burst_dropped <= dropped_nxt;
      burst_error   <= error_nxt;
    end
  end

`ifdef FQ_DEMUX_STATS_EN
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_stat_words
    fq_sat_counter #(.WIDTH(32), .SATURATE(1'b0)) u_words (
      .clk   (clk),
      .rst   (rst),
      .inc   (wrreq_nxt[i]),
      .count (stat_words[i])
    );
  end

  fq_sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_drops (
    .clk   (clk),
    .rst   (rst),
    .inc   (dropped_nxt),
    .count (stat_drops)
  );

  fq_sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_timeouts (
    .clk   (clk),
    .rst   (rst),
    .inc   (error_nxt),
    .count (stat_timeouts)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fq_demux.sv
// tb_fq_demux: directed and randomized bench for fq_demux with a burst-level reference model.
`default_nettype none

module tb_fq_demux;
  localparam int L  = 3;
  localparam int NO = 1 << L;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        fifo_full   [NO];
  logic        fifo_wrreq  [NO];
  logic [63:0] fifo_wrdata [NO];
  logic        burst_done, burst_dropped, burst_error;
`ifdef FQ_DEMUX_STATS_EN
  logic [31:0] stat_words [NO];
  logic [15:0] stat_drops, stat_timeouts;
`endif

  fq_demux #(.NUM_OUT_LOG2(L), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .fifo_full     (fifo_full),
    .fifo_wrreq    (fifo_wrreq),
    .fifo_wrdata   (fifo_wrdata),
    .burst_done    (burst_done),
    .burst_dropped (burst_dropped),
    .burst_error   (burst_error)
`ifdef FQ_DEMUX_STATS_EN
    ,
    .stat_words    (stat_words),
    .stat_drops    (stat_drops),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: burst bookkeeping in plain integers.
  bit          m_ready = 0;
  bit          m_active = 0;
  int          m_left, m_dest, m_idle;
  bit          m_drop;
  bit          m_wrreq [NO];
  logic [63:0] m_wrdata [NO];
  bit          m_done, m_dropped, m_error;
  int          m_swords [NO];
  int          m_sdrops, m_stime;
  int          n;

  always @(posedge clk) begin
    for (int i = 0; i < NO; i++) m_wrreq[i] = 0;
    m_done = 0; m_dropped = 0; m_error = 0;
    if (rst) begin
      m_active = 0; m_drop = 0; m_idle = 0; m_left = 0; m_dest = 0;
      for (int i = 0; i < NO; i++) begin m_wrdata[i] = '0; m_swords[i] = 0; end
      m_sdrops = 0; m_stime = 0;
    end else if (in_valid) begin
      if (!m_active) begin
        n = int'(in_data[7:0]);
        if (n == 0) n = 1;
        m_dest = int'(in_data[8 +: L]);
        m_drop = fifo_full[m_dest];
        m_left = n - 1;
      end else begin
        m_drop = m_drop | fifo_full[m_dest];
        m_left = m_left - 1;
      end
      m_active = (m_left != 0);
      m_idle = 0;
      if (!m_drop) begin
        m_wrreq[m_dest] = 1;
        m_wrdata[m_dest] = in_data;
        m_swords[m_dest] = m_swords[m_dest] + 1;
      end
      if (!m_active) begin
        m_done = 1;
        m_dropped = m_drop;
        if (m_drop && m_sdrops < 65535) m_sdrops++;
        m_drop = 0;
      end
    end else if (m_active) begin
      m_idle++;
      if (m_idle == TO) begin
        m_error = 1; m_active = 0; m_drop = 0; m_idle = 0;
        if (m_stime < 65535) m_stime++;
      end
    end
    m_ready = 1;
  end

  // Observed DUT events, used for hand-computed expectations per scenario.
  int obs_wr [NO];
  int obs_done, obs_dropped, obs_err;

  always @(negedge clk) begin
    logic [NO-1:0] dv, mv;
    int bad;
    if (m_ready) begin
      for (int i = 0; i < NO; i++) begin dv[i] = fifo_wrreq[i]; mv[i] = m_wrreq[i]; end
      checks++;
      if (dv !== mv) begin
        errors++;
        $display("FAIL wrreq t=%0t got %b want %b", $time, dv, mv);
      end
      bad = -1;
      for (int i = 0; i < NO; i++) if (bad < 0 && fifo_wrdata[i] !== m_wrdata[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL wrdata[%0d] t=%0t got %h want %h", bad, $time, fifo_wrdata[bad], m_wrdata[bad]);
      end
      checks++;
      if ({burst_done, burst_dropped, burst_error} !== {m_done, m_dropped, m_error}) begin
        errors++;
        $display("FAIL pulses(done,dropped,error) t=%0t got %b%b%b want %b%b%b", $time,
                 burst_done, burst_dropped, burst_error, m_done, m_dropped, m_error);
      end
`ifdef FQ_DEMUX_STATS_EN
      bad = -1;
      for (int i = 0; i < NO; i++) if (bad < 0 && stat_words[i] !== 32'(m_swords[i])) bad = i;
      checks++;
      if (bad >= 0 || stat_drops !== 16'(m_sdrops) || stat_timeouts !== 16'(m_stime)) begin
        errors++;
        $display("FAIL stats t=%0t got drops=%0d timeouts=%0d want drops=%0d timeouts=%0d (word idx %0d)",
                 $time, stat_drops, stat_timeouts, m_sdrops, m_stime, bad);
      end
`endif
      for (int i = 0; i < NO; i++) if (fifo_wrreq[i] === 1'b1) obs_wr[i]++;
      if (burst_done === 1'b1) obs_done++;
      if (burst_dropped === 1'b1) obs_dropped++;
      if (burst_error === 1'b1) obs_err++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [63:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, '0);
  endtask

  task automatic clr_obs();
    for (int i = 0; i < NO; i++) obs_wr[i] = 0;
    obs_done = 0; obs_dropped = 0; obs_err = 0;
  endtask

  function automatic logic [63:0] word(input logic [15:0] lo);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[15:0] = lo;
    return w;
  endfunction

  int k;
`ifdef FQ_DEMUX_STATS_EN
  logic [31:0] sw7;
`endif

  initial begin
    for (int i = 0; i < NO; i++) fifo_full[i] = 1'b0;
    clr_obs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_wrreq2", int'(fifo_wrreq[2]), 0);
    chk("reset_done", int'(burst_done), 0);

    // Single-word burst to dest 2.
    clr_obs();
    cyc(1'b1, word(16'h0201));
    chk("single_wrreq_now", int'(fifo_wrreq[2]), 1);
    idle(3);
    chk("single_writes", obs_wr[2], 1);
    chk("single_done", obs_done, 1);

    // N=4 to dest 5 with a 3-cycle gap after word 2.
    clr_obs();
    cyc(1'b1, word(16'h0504));
    cyc(1'b1, word(16'h1111));
    idle(3);
    cyc(1'b1, word(16'h2222));
    cyc(1'b1, word(16'h3333));
    idle(3);
    chk("gap_writes", obs_wr[5], 4);
    chk("gap_done", obs_done, 1);
    chk("gap_error", obs_err, 0);

    // Destination full at the header: whole burst dropped.
    clr_obs();
    fifo_full[3] = 1'b1;
    cyc(1'b1, word(16'h0303));
    fifo_full[3] = 1'b0;
    cyc(1'b1, word(16'h0000));
    cyc(1'b1, word(16'h0000));
    idle(3);
    chk("drop_writes", obs_wr[3], 0);
    chk("drop_done", obs_done, 1);
    chk("drop_dropped", obs_dropped, 1);

    // Timeout after 16 idle cycles, then a fresh 2-word burst.
    clr_obs();
    cyc(1'b1, word(16'h0108));
    cyc(1'b1, word(16'h0000));
    cyc(1'b1, word(16'h0000));
    idle(15);
    chk("timeout_early", obs_err, 0);
    idle(1);
    cyc(1'b1, word(16'h0102));
    cyc(1'b1, word(16'h0000));
    idle(3);
    chk("timeout_error", obs_err, 1);
    chk("timeout_writes", obs_wr[1], 5);
    chk("timeout_done", obs_done, 1);

    // Valid word on the cycle the counter would reach TIMEOUT keeps the burst alive.
    clr_obs();
    cyc(1'b1, word(16'h0003));
    idle(TO - 1);
    cyc(1'b1, word(16'h0000));
    idle(TO - 1);
    cyc(1'b1, word(16'h0000));
    idle(3);
    chk("edge_error", obs_err, 0);
    chk("edge_done", obs_done, 1);
    chk("edge_writes", obs_wr[0], 3);

    // Reset after 2 of 5 words.
    clr_obs();
    cyc(1'b1, word(16'h0405));
    cyc(1'b1, word(16'h0000));
    rst = 1'b1;
    cyc(1'b0, '0);
    rst = 1'b0;
    chk("rst_wrreq", int'(fifo_wrreq[4]), 0);
    chk("rst_wrdata", int'(fifo_wrdata[4] != 64'd0), 0);
    cyc(1'b1, word(16'h0401));
    idle(3);
    chk("rst_done", obs_done, 1);
    chk("rst_writes", obs_wr[4], 3);

    // N=0 treated as a single word.
`ifdef FQ_DEMUX_STATS_EN
    sw7 = stat_words[7];
`endif
    clr_obs();
    cyc(1'b1, word(16'h0700));
    idle(3);
    chk("n0_writes", obs_wr[7], 1);
    chk("n0_done", obs_done, 1);
`ifdef FQ_DEMUX_STATS_EN
    chk("n0_stat_words7", int'(stat_words[7] - sw7), 1);
`endif

    // Randomized traffic: short bursts, random full, gaps long enough to time out, occasional reset.
    for (int it = 0; it < 1500; it++) begin
      k = $urandom_range(0, 99);
      for (int i = 0; i < NO; i++) fifo_full[i] = ($urandom_range(0, 9) == 0);
      if (k < 1) begin
        rst = 1'b1;
        cyc(1'b0, '0);
        rst = 1'b0;
      end else if (k < 6) begin
        idle($urandom_range(10, 20));
      end else if (k < 30) begin
        idle(1);
      end else begin
        cyc(1'b1, word({5'($urandom), 3'($urandom), 8'($urandom_range(0, 6))}));
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
